// File: rtl/spi_master_tx.sv
// SPI mode-0 transmitter: shifts one DATA_WIDTH-bit word out LSB first,
// framed by ss_n, with a start pulse at frame begin and a finish pulse at the end.
module spi_master_tx #(
   parameter int DATA_WIDTH = 512,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  ss_n,
   output logic                  start,
   output logic                  busy,
   output logic                  tx_finish
);

   localparam int DIVW = $clog2(CLK_DIV);
   localparam int EDGW = $clog2(DATA_WIDTH) + 1;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
   localparam logic [EDGW-1:0] EDGE_ALL = EDGW'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      DONE
   } state_e;

   state_e                state_q;
   logic [DIVW-1:0]       div_q;
   logic [EDGW-1:0]       edge_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  ss_n_q;
   logic                  start_q;
   logic                  busy_q;
   logic                  fin_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         ss_n_q  <= 1'b1;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         fin_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (tx_start) begin
                  // bit 0 goes straight to mosi; the register holds the rest
                  shreg_q <= {1'b0, tx_data[DATA_WIDTH-1:1]};
                  mosi_q  <= tx_data[0];
                  ss_n_q  <= 1'b0;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  div_q   <= '0;
                  edge_q  <= '0;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  sclk_q  <= 1'b1;
                  edge_q  <= edge_q + EDGW'(1);
                  state_q <= SHIFT;
               end else begin
                  div_q <= div_q + DIVW'(1);
               end
            end
            SHIFT: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     if (edge_q == EDGE_ALL) begin
                        state_q <= HOLD;
                     end else begin
                        mosi_q  <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[DATA_WIDTH-1:1]};
                     end
                  end else begin
                     sclk_q <= 1'b1;
                     edge_q <= edge_q + EDGW'(1);
                  end
               end else begin
                  div_q <= div_q + DIVW'(1);
               end
            end
            HOLD: begin
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  ss_n_q  <= 1'b1;
                  fin_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  div_q <= div_q + DIVW'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               mosi_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign ss_n      = ss_n_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign tx_finish = fin_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: three instances (8/2, 8/5, 512/4) checked
// cycle by cycle against a timing-formula model plus a mode-0 receiver model.
module tb_spi_master_tx;

   logic         clk;
   logic         rst;
   logic         ts;
   logic [511:0] td;
   logic [1:0]   sel;

   logic [2:0] sclk_w, mosi_w, ss_w, st_w, bz_w, fn_w;
   logic [5:0] obs;

   int n_cmp = 0;
   int n_bad = 0;
   int hi_run = 0;
   int last_gap = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(2)) u_a (
      .clk(clk), .rst(rst),
      .tx_start(ts && sel == 2'd0), .tx_data(td[7:0]),
      .sclk(sclk_w[0]), .mosi(mosi_w[0]), .ss_n(ss_w[0]),
      .start(st_w[0]), .busy(bz_w[0]), .tx_finish(fn_w[0])
   );

   spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(5)) u_b (
      .clk(clk), .rst(rst),
      .tx_start(ts && sel == 2'd1), .tx_data(td[7:0]),
      .sclk(sclk_w[1]), .mosi(mosi_w[1]), .ss_n(ss_w[1]),
      .start(st_w[1]), .busy(bz_w[1]), .tx_finish(fn_w[1])
   );

   spi_master_tx #(.DATA_WIDTH(512), .CLK_DIV(4)) u_c (
      .clk(clk), .rst(rst),
      .tx_start(ts && sel == 2'd2), .tx_data(td),
      .sclk(sclk_w[2]), .mosi(mosi_w[2]), .ss_n(ss_w[2]),
      .start(st_w[2]), .busy(bz_w[2]), .tx_finish(fn_w[2])
   );

   // {sclk, mosi, ss_n, start, busy, tx_finish} of the selected instance
   assign obs = {sclk_w[sel], mosi_w[sel], ss_w[sel],
                 st_w[sel], bz_w[sel], fn_w[sel]};

   always @(negedge clk) begin
      if (obs[3]) begin
         hi_run = hi_run + 1;
      end else begin
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
      end
   end

   function automatic logic [511:0] rand_word();
      logic [511:0] w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic launch(input logic [511:0] d);
      @(posedge clk);
      #1;
      td = d;
      ts = 1'b1;
      @(posedge clk);
      #1;
      ts = 1'b0;
      td = rand_word();
   endtask

   // Called so that the next negedge is the first cycle after acceptance.
   task automatic check_frame(input logic [511:0] d, input int dw,
                              input int cd, input string nm);
      int done_n, m, f, run, nrise, bad_hi, bad_lo, bad_mo, nfin;
      int errs[6];
      int fst[6];
      string sn[6];
      logic [5:0] e, o, prev, fact, fexp;
      logic [511:0] rx, mask;
      sn[5] = "sclk"; sn[4] = "mosi"; sn[3] = "ss_n";
      sn[2] = "start"; sn[1] = "busy"; sn[0] = "tx_finish";
      done_n = (2 * dw + 1) * cd + 1;
      for (int i = 0; i < 6; i++) begin
         errs[i] = 0;
         fst[i] = 0;
      end
      fact = '0;
      fexp = '0;
      run = 0; nrise = 0; nfin = 0;
      bad_hi = 0; bad_lo = 0; bad_mo = 0;
      rx = '0;
      mask = '0;
      for (int i = 0; i < dw; i++) mask[i] = 1'b1;
      prev = 6'b001000;
      for (int n = 1; n <= done_n + 1; n++) begin
         @(negedge clk);
         o = obs;
         m = n - 1;
         e[5] = (m >= cd) && (m < 2 * dw * cd) && ((m / cd) % 2 == 1);
         f = m / (2 * cd);
         if (f > dw - 1) f = dw - 1;
         e[4] = (n <= done_n) ? d[f] : 1'b0;
         e[3] = (n >= done_n);
         e[2] = (n == 1);
         e[1] = (n <= done_n);
         e[0] = (n == done_n);
         for (int i = 0; i < 6; i++) begin
            if (o[i] !== e[i]) begin
               if (errs[i] == 0) begin
                  fst[i] = n;
                  fact[i] = o[i];
                  fexp[i] = e[i];
               end
               errs[i]++;
            end
         end
         if (o[5] === prev[5]) begin
            run++;
         end else begin
            if (prev[5]) begin
               if (run != cd) bad_hi++;
            end else if (run != cd) begin
               bad_lo++;
            end
            run = 1;
         end
         if (o[5] && !prev[5]) begin
            if (nrise < 512) rx[nrise] = o[4];
            nrise++;
         end
         if (o[4] !== prev[4] && o[5]) bad_mo++;
         if (o[0]) nfin++;
         prev = o;
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (errs[i] != 0) begin
            n_bad++;
            $display("FAIL %s %s: %0d bad cycles, first n=%0d got %b want %b",
                     nm, sn[i], errs[i], fst[i], fact[i], fexp[i]);
         end
      end
      n_cmp++;
      if (nrise !== dw) begin
         n_bad++;
         $display("FAIL %s sclk_rises: got %0d want %0d", nm, nrise, dw);
      end
      n_cmp++;
      if (bad_hi !== 0) begin
         n_bad++;
         $display("FAIL %s sclk_high_time: got %0d bad runs want 0", nm, bad_hi);
      end
      n_cmp++;
      if (bad_lo !== 0) begin
         n_bad++;
         $display("FAIL %s sclk_low_time: got %0d bad runs want 0", nm, bad_lo);
      end
      n_cmp++;
      if (bad_mo !== 0) begin
         n_bad++;
         $display("FAIL %s mosi_stable: got %0d changes in sclk high want 0",
                  nm, bad_mo);
      end
      n_cmp++;
      if ((rx & mask) !== (d & mask)) begin
         n_bad++;
         $display("FAIL %s rx_word: got %h want %h", nm, rx & mask, d & mask);
      end
      n_cmp++;
      if (nfin !== 1) begin
         n_bad++;
         $display("FAIL %s finish_count: got %0d want 1", nm, nfin);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ts = 1'b1;
      td = rand_word();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ts = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({sclk_w[i], mosi_w[i], ss_w[i], st_w[i], bz_w[i], fn_w[i]}
             !== 6'b001000) begin
            n_bad++;
            $display("FAIL reset_vals[%0d]: got %b want 001000", i,
                     {sclk_w[i], mosi_w[i], ss_w[i], st_w[i], bz_w[i], fn_w[i]});
         end
      end
      @(negedge clk);
      n_cmp++;
      if (obs !== 6'b001000) begin
         n_bad++;
         $display("FAIL rst_wins_idle: got %b want 001000", obs);
      end
   endtask

   task automatic test_basic();
      logic [511:0] d;
      sel = 2'd0;
      d = '0;
      d[7:0] = 8'hA5;
      launch(d);
      check_frame(d, 8, 2, "basic_a5");
   endtask

   task automatic test_ignore_start();
      logic [511:0] d;
      sel = 2'd0;
      d = '0;
      d[7:0] = 8'hA5;
      launch(d);
      fork
         check_frame(d, 8, 2, "ignore_start");
         begin
            repeat (9) @(posedge clk);
            #1;
            ts = 1'b1;
            td = {64{8'hFF}};
            @(posedge clk);
            #1;
            ts = 1'b0;
         end
      join
   endtask

   task automatic test_back_to_back();
      logic [511:0] d1, d2;
      sel = 2'd0;
      d1 = rand_word();
      d2 = rand_word();
      @(posedge clk);
      #1;
      td = d1;
      ts = 1'b1;
      @(posedge clk);
      #1;
      td = d2;
      check_frame(d1, 8, 2, "b2b_first");
      fork
         check_frame(d2, 8, 2, "b2b_second");
         begin
            @(posedge clk);
            #1;
            ts = 1'b0;
            td = rand_word();
         end
      join
      // DONE cycle plus the single IDLE cycle that accepts the next request
      n_cmp++;
      if (last_gap !== 2) begin
         n_bad++;
         $display("FAIL b2b_ss_gap: got %0d want 2", last_gap);
      end
   endtask

   task automatic test_reset_midframe();
      logic [511:0] d;
      int odd;
      sel = 2'd0;
      launch(rand_word());
      repeat (15) @(negedge clk);
      n_cmp++;
      if (obs[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_4th_rise: got %b want 1", obs[5]);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== 6'b001000) begin
         n_bad++;
         $display("FAIL midrst_vals: got %b want 001000", obs);
      end
      odd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (obs !== 6'b001000) odd++;
      end
      n_cmp++;
      if (odd !== 0) begin
         n_bad++;
         $display("FAIL midrst_quiet: got %0d active cycles want 0", odd);
      end
      d = '0;
      d[7:0] = 8'h3C;
      launch(d);
      check_frame(d, 8, 2, "after_rst_3c");
   endtask

   task automatic test_clkdiv();
      logic [511:0] d;
      sel = 2'd1;
      d = rand_word();
      launch(d);
      check_frame(d, 8, 5, "div5");
      sel = 2'd0;
      d = rand_word();
      launch(d);
      check_frame(d, 8, 2, "div2");
   endtask

   task automatic test_loopback();
      logic [511:0] d;
      sel = 2'd2;
      d = rand_word();
      launch(d);
      check_frame(d, 512, 4, "loop512");
      sel = 2'd0;
   endtask

   initial begin
      rst = 1'b1;
      ts = 1'b0;
      td = '0;
      sel = 2'd0;
      test_reset();
      test_basic();
      test_ignore_start();
      test_back_to_back();
      test_reset_midframe();
      test_clkdiv();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
